// File: rtl/parking_controller_multi.sv
// Multi-space parking gate controller: password-gated entry FSM with retry lockout and entry timeout,
// plus an occupancy counter fed by entry commits and exit-sensor edges.
module parking_controller_multi #(
    parameter int                  CAPACITY    = 4,
    parameter int                  PW_WIDTH    = 4,
    parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'hA,
    parameter int                  WAIT_CYCLES = 20,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCK_CYCLES = 32,
    localparam int                 CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_entrance,
    input  logic                sensor_exit,
    input  logic                pw_valid,
    input  logic [PW_WIDTH-1:0] pw_in,
    output logic                green_led,
    output logic                red_led,
    output logic                gate_open,
    output logic                full,
    output logic [CNT_W-1:0]    occupancy,
    output logic [CNT_W-1:0]    free_spaces,
    output logic [2:0]          fsm_state
);

    localparam int TMAX  = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PW  = 3'd1,
        S_WRONG_PW = 3'd2,
        S_RIGHT_PW = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [TRY_W-1:0]   r_tries;
    logic               r_entr_d;
    logic               r_exit_d;
    logic [CNT_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_free;
    logic               r_full;
    logic               r_green;
    logic               r_red;
    logic               r_gate;

    state_t             w_state_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic [TRY_W-1:0]   w_tries_inc;
    logic               w_commit;
    logic               w_wrong_entry;
    logic               w_exit_edge;
    logic [CNT_W-1:0]   w_occ_nxt;
    logic               w_red_nxt;

    // Next-state, timer and retry-count logic for the entry session FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + TMR_W'(1);
        w_tries_nxt   = r_tries;
        w_tries_inc   = r_tries + TRY_W'(1);
        w_commit      = 1'b0;
        w_wrong_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = {TMR_W{1'b0}};
                w_tries_nxt = {TRY_W{1'b0}};
                // Admission looks at the live count so a back-to-back arrival can never overfill
                if (sensor_entrance && (r_occ != CAP_C)) begin
                    w_state_nxt = S_WAIT_PW;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_PW, S_WRONG_PW: begin
                if (pw_valid) begin
                    w_timer_nxt = {TMR_W{1'b0}};
                    if (pw_in == PASSWORD) begin
                        w_state_nxt = S_RIGHT_PW;
                    end else begin
                        w_tries_nxt   = w_tries_inc;
                        w_wrong_entry = 1'b1;
                        if (w_tries_inc == TRY_LIMIT) begin
                            w_state_nxt = S_LOCKOUT;
                        end else begin
                            w_state_nxt = S_WRONG_PW;
                        end
                    end
                end else if (r_timer == WAIT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = {TMR_W{1'b0}};
                    w_tries_nxt = {TRY_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RIGHT_PW: begin
                w_timer_nxt = {TMR_W{1'b0}};
                if (r_entr_d && !sensor_entrance) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RIGHT_PW;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == LOCK_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = {TMR_W{1'b0}};
                    w_tries_nxt = {TRY_W{1'b0}};
                end else begin
                    w_state_nxt = S_LOCKOUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = {TMR_W{1'b0}};
                w_tries_nxt = {TRY_W{1'b0}};
            end
        endcase
    end

    // Occupancy update: a commit and an exit edge in the same cycle cancel out
    always_comb begin
        w_exit_edge = sensor_exit & ~r_exit_d;
        if (w_commit && w_exit_edge) begin
            w_occ_nxt = r_occ;
        end else if (w_commit && (r_occ != CAP_C)) begin
            w_occ_nxt = r_occ + CNT_W'(1);
        end else if (w_exit_edge && (r_occ != {CNT_W{1'b0}})) begin
            w_occ_nxt = r_occ - CNT_W'(1);
        end else begin
            w_occ_nxt = r_occ;
        end
    end

    // Red indicator for the upcoming state; in IDLE it tracks the full flag being registered alongside
    always_comb begin
        case (w_state_nxt)
            S_IDLE:     w_red_nxt = (r_occ == CAP_C);
            S_WAIT_PW:  w_red_nxt = 1'b1;
            S_WRONG_PW: w_red_nxt = w_wrong_entry ? 1'b1 : ~r_red;
            S_RIGHT_PW: w_red_nxt = 1'b0;
            S_LOCKOUT:  w_red_nxt = 1'b1;
            default:    w_red_nxt = 1'b0;
        endcase
    end

    // State, counters, edge detectors and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_timer  <= {TMR_W{1'b0}};
            r_tries  <= {TRY_W{1'b0}};
            r_entr_d <= 1'b0;
            r_exit_d <= 1'b0;
            r_occ    <= {CNT_W{1'b0}};
            r_free   <= CAP_C;
            r_full   <= 1'b0;
            r_green  <= 1'b0;
            r_red    <= 1'b0;
            r_gate   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_tries  <= w_tries_nxt;
            r_entr_d <= sensor_entrance;
            r_exit_d <= sensor_exit;
            r_occ    <= w_occ_nxt;
            r_free   <= CAP_C - r_occ;
            r_full   <= (r_occ == CAP_C);
            r_green  <= (w_state_nxt == S_RIGHT_PW);
            r_gate   <= (w_state_nxt == S_RIGHT_PW);
            r_red    <= w_red_nxt;
        end
    end

    assign green_led   = r_green;
    assign red_led     = r_red;
    assign gate_open   = r_gate;
    assign full        = r_full;
    assign occupancy   = r_occ;
    assign free_spaces = r_free;
    assign fsm_state   = r_state;

endmodule
